// File: rtl/apb_slave_mem_if.sv
// ============================================================================
// Module   : apb_slave_mem_if
// Brief    : APB bus bundle between a master and the apb_slave_mem endpoint.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface apb_slave_mem_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  PSELx;
  logic                  PENABLE;
  logic [31:0]           PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PWRITE;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    output PSELx, PENABLE, PADDR, PWDATA, PWRITE,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PADDR, PWDATA, PWRITE,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

`default_nettype wire

// File: rtl/apb_slave_mem.sv
// ============================================================================
// Module   : apb_slave_mem
// Brief    : APB register memory with configurable wait states and PSLVERR.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  apb_slave_mem_if.slave  apb
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  err_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]      idx;
  logic                  err_d;

  // DEPTH is a power of two, so "out of range" is simply any set bit above the index field.
  assign idx   = apb.PADDR[2 +: IDX_W];
  assign err_d = (apb.PADDR[1:0] != 2'b00) || (apb.PADDR[31:IDX_W+2] != '0);

  assign apb.PREADY  = pready_q;
  assign apb.PRDATA  = prdata_q;
  assign apb.PSLVERR = pslverr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (apb.PSELx && !apb.PENABLE) begin
            err_q <= err_d;
            if (WAIT_STATES == 0) begin
              state_q   <= S_DONE;
              pready_q  <= 1'b1;
              pslverr_q <= err_d;
              prdata_q  <= (!apb.PWRITE && !err_d) ? mem_q[idx] : '0;
            end else begin
              cnt_q   <= CNT_INIT;
              state_q <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (!apb.PSELx) begin
            state_q <= S_IDLE;
          end else if (cnt_q == 4'd0) begin
            state_q   <= S_DONE;
            pready_q  <= 1'b1;
            pslverr_q <= err_q;
            prdata_q  <= (!apb.PWRITE && !err_q) ? mem_q[idx] : '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        S_DONE: begin
          // Write commits here so a back-to-back read of the same word sees it.
          if (apb.PSELx && apb.PENABLE && apb.PWRITE && !err_q) begin
            mem_q[idx] <= apb.PWDATA;
          end
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          state_q   <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB slave register memory that sits directly downstream of apb_master and consumes its PSELx/PENABLE/PADDR/PWDATA/PWRITE bus.
- Returns PREADY with a parameterised wait-state count, returns read data, and flags out-of-range or unaligned accesses on PSLVERR.
- Serves as the bus endpoint for system integration and for closed-loop master/slave verification.

Parameters:
- DATA_WIDTH, 32, width of PWDATA/PRDATA and of each memory word.
- DEPTH, 16, number of words; power of two, 2..256.
- WAIT_STATES, 0, number of ACCESS cycles with PREADY=0 before completion; range 0..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- PSELx  input  1  slave select from master.
- PENABLE  input  1  access-phase indicator from master.
- PADDR  input  32  byte address; word index = PADDR[2 +: log2(DEPTH)].
- PWDATA  input  DATA_WIDTH  write data.
- PWRITE  input  1  1 = write, 0 = read.
- PREADY  output  1  transfer complete (registered).
- PRDATA  output  DATA_WIDTH  read data, valid only while PREADY=1 (registered).
- PSLVERR  output  1  error response, valid only while PREADY=1 (registered).

Behaviour:
- Reset (reset_n=0, async): state=IDLE, PREADY=0, PRDATA=0, PSLVERR=0, wait counter=0, all memory words=0.
- Address error: err = (PADDR[1:0]!=0) or (PADDR >= DEPTH*4). It is evaluated on the setup-detect edge and held until the transfer ends.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - PREADY=0.
  - On an edge with PSELx=1 and PENABLE=0 (setup phase), latch err.
  - If WAIT_STATES==0, go to DONE. Otherwise load counter=WAIT_STATES-1 and go to WAIT.
  - PSELx=1 with PENABLE=1 seen in IDLE is a protocol violation: ignore it and stay in IDLE.
- WAIT:
  - PREADY=0.
  - If PSELx=0 (aborted transfer), go to IDLE with no write.
  - Else if counter==0, go to DONE. Else decrement the counter.
  - Result: exactly WAIT_STATES ACCESS cycles with PREADY=0 for WAIT_STATES>0.
- Entering DONE (registered on the same edge):
  - PREADY<=1.
  - PSLVERR<=err.
  - PRDATA<=mem[index] when read and !err; else 0.
- DONE:
  - PREADY=1 for exactly one cycle.
  - On the edge ending DONE: if PSELx & PENABLE & PWRITE & !err, then mem[index]<=PWDATA.
  - Also on that edge, unconditionally: PREADY<=0, PSLVERR<=0, PRDATA<=0, next state=IDLE.
- Latency, zero-wait case: setup cycle n, ACCESS cycle n+1 with PREADY=1, transfer completes at the end of n+1.
- Latency, general: completes in cycle n+1+WAIT_STATES.
- Back-to-back: the master may present a new setup phase in the cycle right after DONE. IDLE detects it with no bubble, and the next transfer behaves identically.
- Read-after-write to the same word in consecutive transfers returns the new data, because the write commits before the next setup edge.
- An errored write leaves memory unchanged; an errored read returns PRDATA=0.
- PADDR upper bits beyond the index field participate only in the range check.
- Reset mid-transfer (any state): immediate return to IDLE with outputs and memory cleared. The master is also reset and restarts from IDLE.

Test Plan:
- WAIT_STATES=0: write addr 0x04 data 0xDEADBEEF, then read 0x04 -> PREADY=1 in the first ACCESS cycle of each transfer; read PRDATA=0xDEADBEEF, PSLVERR=0.
- WAIT_STATES=2: read 0x08 after writing 0x12345678 -> PREADY low for 2 ACCESS cycles, high on the 3rd; PRDATA=0x12345678 only in that cycle, 0 otherwise.
- DEPTH=16: write 0x40 (out of range) data 0xFFFFFFFF, then read 0x00..0x3C -> PSLVERR=1 on the write with PRDATA=0; all words unchanged (0).
- Unaligned read at 0x06 -> PSLVERR=1, PRDATA=0; a following aligned read at 0x04 has PSLVERR=0.
- Back-to-back, transfer held high: 4 writes to 0x00/0x04/0x08/0x0C, then 4 reads -> no idle cycles between transfers; readback matches; PREADY pulses once per transfer.
- WAIT_STATES=3: assert reset_n=0 during the 2nd wait cycle of a write to 0x10 -> PREADY/PRDATA/PSLVERR go to 0 immediately; after release, read 0x10 returns 0.
